// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage_if
//  Description : Execute-stage bundle. Carries the decode/execute (_E) inputs,
//                the memory-stage stall, the front-end busy flag and the
//                execute/memory (_M) pipeline-register outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ex_stage_if;
   // decode/execute bundle
   logic        VALID_E;
   logic [4:0]  opcode_E;
   logic [4:0]  shamt_E;
   logic [2:0]  cond_E;
   logic        ALUSRC1_E;
   logic [2:0]  ALUSRC2_E;
   logic [31:0] RD1_E;
   logic [31:0] RD2_E;
   logic [31:0] Iext_E;
   logic [31:0] zeroExt_E;
   logic [31:0] Jext_E;
   logic [31:0] PCADD4_E;
   logic [1:0]  WDSRC_E;
   logic        WEN_E;
   logic        MemToReg_E;
   logic        DRW_E;
   logic        DREQ_E;
   // flow control
   logic        STALL_M;
   logic        BUSY_E;
   // execute/memory bundle
   logic        VALID_M;
   logic [31:0] ALUOUT_M;
   logic [31:0] RD2_M;
   logic [31:0] PCADD4_M;
   logic [1:0]  WDSRC_M;
   logic        WEN_M;
   logic        MemToReg_M;
   logic        DRW_M;
   logic        DREQ_M;
   logic        BR_TAKEN_M;
   logic [31:0] BR_TARGET_M;

   // driven by the front end / memory stage
   modport master (
      output VALID_E, opcode_E, shamt_E, cond_E, ALUSRC1_E, ALUSRC2_E,
             RD1_E, RD2_E, Iext_E, zeroExt_E, Jext_E, PCADD4_E,
             WDSRC_E, WEN_E, MemToReg_E, DRW_E, DREQ_E, STALL_M,
      input  BUSY_E, VALID_M, ALUOUT_M, RD2_M, PCADD4_M, WDSRC_M, WEN_M,
             MemToReg_M, DRW_M, DREQ_M, BR_TAKEN_M, BR_TARGET_M
   );

   // seen from the execute stage
   modport slave (
      input  VALID_E, opcode_E, shamt_E, cond_E, ALUSRC1_E, ALUSRC2_E,
             RD1_E, RD2_E, Iext_E, zeroExt_E, Jext_E, PCADD4_E,
             WDSRC_E, WEN_E, MemToReg_E, DRW_E, DREQ_E, STALL_M,
      output BUSY_E, VALID_M, ALUOUT_M, RD2_M, PCADD4_M, WDSRC_M, WEN_M,
             MemToReg_M, DRW_M, DREQ_M, BR_TAKEN_M, BR_TARGET_M
   );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage: ALU, shifter, branch resolution and the
//                execute/memory pipeline register. Shifts run 1 bit/cycle
//                unless EX_FAST_SHIFT_EN is defined (single-cycle barrel).
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage (
   input  wire logic CLK,
   input  wire logic RST,
   ex_stage_if.slave ex
);
   localparam logic [4:0] c_op_lsr = 5'd11;
   localparam logic [4:0] c_op_asr = 5'd12;
   localparam logic [4:0] c_op_shl = 5'd13;
   localparam logic [4:0] c_op_ror = 5'd14;

   logic [31:0] opa_w, opb_w, alu_w, shres_w, result_w, target_w;
   logic [4:0]  n_w;
   logic        is_shift_w, cond_w, taken_w, done_w, busy_w;

   // operand selection
   always_comb begin
      opa_w = ex.ALUSRC1_E ? ex.PCADD4_E : ex.RD1_E;
      case (ex.ALUSRC2_E)
         3'd1:    opb_w = ex.Iext_E;
         3'd2:    opb_w = ex.zeroExt_E;
         3'd3:    opb_w = ex.Jext_E;
         3'd4:    opb_w = {27'b0, ex.shamt_E};
         default: opb_w = ex.RD2_E;
      endcase
   end

   assign n_w        = opb_w[4:0];
   assign is_shift_w = (ex.opcode_E >= c_op_lsr) && (ex.opcode_E <= c_op_ror);

   // non-shift ALU operations, links and address generation
   always_comb begin
      alu_w = 32'd0;
      case (ex.opcode_E)
         5'd0, 5'd4, 5'd19, 5'd20, 5'd21, 5'd22: alu_w = opa_w + opb_w;
         5'd5:        alu_w = opa_w - opb_w;
         5'd1, 5'd8:  alu_w = opa_w & opb_w;
         5'd2, 5'd9:  alu_w = opa_w | opb_w;
         5'd10:       alu_w = opa_w ^ opb_w;
         5'd3:        alu_w = opb_w;
         5'd6:        alu_w = 32'd0 - opb_w;
         5'd7:        alu_w = ~opb_w;
         5'd16, 5'd18: alu_w = ex.PCADD4_E;
         default:     alu_w = 32'd0;
      endcase
   end

   // branch condition on RD2 and redirect target
   always_comb begin
      case (ex.cond_E)
         3'd1:    cond_w = 1'b1;
         3'd2:    cond_w = (ex.RD2_E == 32'd0);
         3'd3:    cond_w = (ex.RD2_E != 32'd0);
         3'd4:    cond_w = ~ex.RD2_E[31];
         3'd5:    cond_w = ex.RD2_E[31];
         default: cond_w = 1'b0;
      endcase
      taken_w  = 1'b0;
      target_w = 32'd0;
      case (ex.opcode_E)
         5'd15, 5'd16: begin taken_w = cond_w; target_w = ex.RD1_E; end
         5'd17, 5'd18: begin taken_w = 1'b1;   target_w = ex.PCADD4_E + ex.Jext_E; end
         default: ;
      endcase
   end

`ifdef EX_FAST_SHIFT_EN
   logic [63:0] rot_w;

   // single-cycle barrel shifter; rotate taken from a doubled word
   always_comb begin
      rot_w = {opa_w, opa_w} >> n_w;
      case (ex.opcode_E)
         c_op_lsr: shres_w = opa_w >> n_w;
         c_op_asr: shres_w = $signed(opa_w) >>> n_w;
         c_op_shl: shres_w = opa_w << n_w;
         default:  shres_w = rot_w[31:0];
      endcase
   end

   assign done_w = ex.VALID_E;
   assign busy_w = ex.STALL_M;
`else
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] acc_q, acc_d;
   logic [4:0]  cnt_q, cnt_d;

   function automatic logic [31:0] shift1_f(input logic [4:0] op, input logic [31:0] x);
      case (op)
         c_op_lsr: shift1_f = {1'b0, x[31:1]};
         c_op_asr: shift1_f = {x[31], x[31:1]};
         c_op_shl: shift1_f = {x[30:0], 1'b0};
         default:  shift1_f = {x[0], x[31:1]};
      endcase
   endfunction

   // serial shift sequencer: next state, accumulator, completion and busy
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      done_w  = 1'b0;
      busy_w  = ex.STALL_M;
      shres_w = (n_w == 5'd0) ? opa_w : shift1_f(ex.opcode_E, opa_w);
      case (state_q)
         S_IDLE: begin
            if (ex.VALID_E && is_shift_w && (n_w >= 5'd2)) begin
               busy_w = 1'b1;
               if (!ex.STALL_M) begin
                  acc_d   = shift1_f(ex.opcode_E, opa_w);
                  cnt_d   = n_w - 5'd1;
                  state_d = S_SHIFT;
               end
            end else begin
               done_w = ex.VALID_E;
            end
         end
         default: begin
            shres_w = shift1_f(ex.opcode_E, acc_q);
            if (cnt_q > 5'd1) busy_w = 1'b1;
            if (!ex.STALL_M) begin
               acc_d = shift1_f(ex.opcode_E, acc_q);
               cnt_d = cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  done_w  = 1'b1;
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   // sequencer state register; reset aborts any shift in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         acc_q   <= 32'd0;
         cnt_q   <= 5'd0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end
`endif

   assign result_w  = is_shift_w ? shres_w : alu_w;
   assign ex.BUSY_E = busy_w;

   logic        valid_q, wen_q, memtoreg_q, drw_q, dreq_q, taken_q;
   logic [31:0] aluout_q, rd2_q, pcadd4_q, target_q;
   logic [1:0]  wdsrc_q;

   // execute/memory register: holds on stall, bubble when nothing completes
   always_ff @(posedge CLK) begin
      if (RST || (!ex.STALL_M && !done_w)) begin
         valid_q    <= 1'b0;
         aluout_q   <= 32'd0;
         rd2_q      <= 32'd0;
         pcadd4_q   <= 32'd0;
         wdsrc_q    <= 2'd0;
         wen_q      <= 1'b0;
         memtoreg_q <= 1'b0;
         drw_q      <= 1'b0;
         dreq_q     <= 1'b0;
         taken_q    <= 1'b0;
         target_q   <= 32'd0;
      end else if (!ex.STALL_M) begin
         valid_q    <= 1'b1;
         aluout_q   <= result_w;
         rd2_q      <= ex.RD2_E;
         pcadd4_q   <= ex.PCADD4_E;
         wdsrc_q    <= ex.WDSRC_E;
         wen_q      <= ex.WEN_E;
         memtoreg_q <= ex.MemToReg_E;
         drw_q      <= ex.DRW_E;
         dreq_q     <= ex.DREQ_E;
         taken_q    <= taken_w;
         target_q   <= target_w;
      end
   end

   assign ex.VALID_M     = valid_q;
   assign ex.ALUOUT_M    = aluout_q;
   assign ex.RD2_M       = rd2_q;
   assign ex.PCADD4_M    = pcadd4_q;
   assign ex.WDSRC_M     = wdsrc_q;
   assign ex.WEN_M       = wen_q;
   assign ex.MemToReg_M  = memtoreg_q;
   assign ex.DRW_M       = drw_q;
   assign ex.DREQ_M      = dreq_q;
   assign ex.BR_TAKEN_M  = taken_q;
   assign ex.BR_TARGET_M = target_q;
endmodule
`default_nettype wire

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 5-stage RISC-toy pipeline: consumes the registered decode/execute (`_E`) bundle, computes the ALU/shift result, resolves branches and jumps, and owns the execute/memory (`_M`) pipeline register. Shifts are iterative by default (1 bit/cycle), so the stage can occupy E for several cycles; it back-pressures the front end through `BUSY_E`. It also honours a memory-stage stall.

## Interface
- No parameters; datapath fixed at 32 bits.
- `CLK` in 1: sole clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `VALID_E` in 1: E bundle holds a real instruction.
- `STALL_M` in 1: memory stage cannot accept; hold the `_M` register.
- `opcode_E` in 5, `shamt_E` in 5, `cond_E` in 3, `ALUSRC1_E` in 1, `ALUSRC2_E` in 3: operation controls.
- `RD1_E`, `RD2_E`, `Iext_E`, `zeroExt_E`, `Jext_E`, `PCADD4_E` in 32 each: operands.
- `WDSRC_E` in 2, `WEN_E`, `MemToReg_E`, `DRW_E`, `DREQ_E` in 1 each: passthrough controls.
- `BUSY_E` out 1: combinational; front end (IF/ID/DE) must freeze while high.
- `VALID_M` out 1; `ALUOUT_M`, `RD2_M`, `PCADD4_M` out 32; `WDSRC_M` out 2; `WEN_M`, `MemToReg_M`, `DRW_M`, `DREQ_M` out 1: registered bundle.
- `BR_TAKEN_M` out 1, `BR_TARGET_M` out 32: registered redirect, valid with `VALID_M`.

## Operation
- Operand A = `ALUSRC1_E` ? `PCADD4_E` : `RD1_E`.
- Operand B by `ALUSRC2_E`: 0 `RD2_E`, 1 `Iext_E`, 2 `zeroExt_E`, 3 `Jext_E`, 4 `{27'b0,shamt_E}`, 5–7 `RD2_E`.
- Opcodes: 0 ADDI/4 ADD A+B; 5 SUB A−B; 1 ANDI/8 AND; 2 ORI/9 OR; 10 XOR; 3 MOVI B; 6 NEG −B; 7 NOT ~B; 11 LSR, 12 ASR, 13 SHL, 14 ROR of A by n = B[4:0]; 15 BR, 16 BRL, 17 J, 18 JL; 19–22 LD/LDR/ST/STR → A+B (address). Other opcodes → ALUOUT 0. All arithmetic mod 2^32, no flags.
- Condition on `RD2_E` by `cond_E`: 0 never, 1 always, 2 ==0, 3 !=0, 4 signed ≥0, 5 signed <0, 6–7 never.
- BR/BRL: taken iff condition true, target `RD1_E`. J/JL: always taken, target `PCADD4_E + Jext_E`. BRL/JL: ALUOUT = `PCADD4_E` (link).
- `RD2_M` carries `RD2_E` (store data); other controls pass through unchanged.
- Shift FSM (serial build), states IDLE, SHIFT:
  - IDLE: valid shift, n ≤ 1, `!STALL_M` → result computed directly and loaded into `_M`.
  - IDLE: valid shift, n ≥ 2, `!STALL_M` → acc ← A shifted 1, cnt ← n−1, go SHIFT, `BUSY_E`=1.
  - SHIFT: acc shifts 1/cycle, cnt−1. `BUSY_E`=1 while cnt > 1. The cnt = 1 cycle performs the last shift, loads `_M`, returns IDLE, `BUSY_E`=0.
  - Net: a shift by n occupies E for max(n,1) cycles.
- `STALL_M`=1: `_M` register holds, FSM frozen, `BUSY_E`=1.
- Bubble: if `!STALL_M` and (`!VALID_E` or FSM still busy), `_M` loads VALID 0 with `WEN_M`, `DREQ_M`, `BR_TAKEN_M` all 0.

## Timing
- Reset: all `_M` outputs 0, `BR_TAKEN_M`=0, `BR_TARGET_M`=0, FSM IDLE, `BUSY_E`=0. RST mid-shift aborts the shift; no `_M` load.
- Non-shift and n ≤ 1 shift latency: 1 cycle, E inputs to `_M`.
- Shift n ≥ 2 latency: n cycles. E inputs must stay stable while `BUSY_E`=1.
- `BR_TAKEN_M` is a 1-cycle pulse per taken branch, unless held by `STALL_M`. Flushing younger instructions belongs to the hazard unit.
- Simultaneous `STALL_M` and shift completion: stall wins; completion retries next unstalled cycle.

## Configuration
- `EX_FAST_SHIFT_EN` defined: single-cycle barrel shifter. All shifts take 1 cycle; FSM absent; `BUSY_E` = `STALL_M`.
- Undefined: serial shifter as above. Results are identical in both builds; only latency differs.

## Test plan
- ADD with RD1=0x7FFFFFFF, RD2=1, ALUSRC2=0 → next cycle ALUOUT_M=0x80000000, VALID_M=1.
- ASR with A=0x80000000, ALUSRC2=4, shamt=4 → BUSY_E high 3 cycles, ALUOUT_M=0xF8000000 at cycle 4. Fast build: cycle 1.
- BR cond=5, RD2=0xFFFFFFFF, RD1=0x100 → BR_TAKEN_M=1, BR_TARGET_M=0x100. Same with RD2=0 → BR_TAKEN_M=0.
- JL with PCADD4=0x40, Jext=0x10 → target 0x50, ALUOUT_M=0x40.
- ROR by 8 of 0x12345678 with STALL_M high 2 cycles mid-shift → ALUOUT_M=0x78123456, load delayed 2 cycles, `_M` unchanged during stall.
- RST asserted in cycle 2 of SHL by 10 → next cycle VALID_M=0, BUSY_E=0, FSM IDLE.
